// File: rtl/load_unit.sv
// Byte-serial load unit: fetches 1/2/4 bytes from a byte-wide memory with a
// one-cycle read latency and returns the sign/zero-extended little-endian result.
module load_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [2:0]        f3, f3_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [1:0]        last_idx;
  logic              cap_en;
  logic [1:0]        cap_lane;
  logic [3:0][7:0]   lanes, lanes_nx;

  logic              busy_nx, done_nx, err_nx, mem_rd_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [31:0]       rdata_nx;

  function automatic logic legal_req(input logic [2:0] f, input logic [1:0] a);
    case (f)
      3'b000, 3'b100: legal_req = 1'b1;
      3'b001, 3'b101: legal_req = ~a[0];
      3'b010:         legal_req = (a == 2'b00);
      default:        legal_req = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f, input logic [3:0][7:0] b);
    case (f)
      3'b000:  extend = {{24{b[0][7]}}, b[0]};
      3'b100:  extend = {24'd0, b[0]};
      3'b001:  extend = {{16{b[1][7]}}, b[1], b[0]};
      3'b101:  extend = {16'd0, b[1], b[0]};
      default: extend = {b[3], b[2], b[1], b[0]};
    endcase
  endfunction

  // Index of the final byte issued for the registered load type
  always_comb begin
    last_idx = 2'd0;
    case (f3[1:0])
      2'b01:   last_idx = 2'd1;
      2'b10:   last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      base     <= '0;
      f3       <= '0;
      cnt      <= '0;
      cap_en   <= 1'b0;
      cap_lane <= '0;
      lanes    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      rdata    <= '0;
    end else begin
      state    <= state_nx;
      base     <= base_nx;
      f3       <= f3_nx;
      cnt      <= cnt_nx;
      cap_en   <= (state == S_ISSUE);
      cap_lane <= cnt;
      lanes    <= lanes_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
      mem_rd   <= mem_rd_nx;
      mem_addr <= mem_addr_nx;
      rdata    <= rdata_nx;
    end
  end

  // Next state; start is only honoured in IDLE and DONE
  always_comb begin
    state_nx = state;
    base_nx  = base;
    f3_nx    = f3;
    cnt_nx   = cnt;
    case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (start) begin
          base_nx  = addr;
          f3_nx    = funct3;
          cnt_nx   = 2'd0;
          state_nx = legal_req(funct3, addr[1:0]) ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        if (cnt == last_idx) state_nx = S_DRAIN;
        else                 cnt_nx   = cnt + 2'd1;
      end
      S_DRAIN: state_nx = S_DONE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state; the byte returned this
  // cycle is merged so the final lane is visible in the DONE cycle's rdata.
  always_comb begin
    lanes_nx = lanes;
    if (cap_en) lanes_nx[cap_lane] = mem_rdata;
    busy_nx     = (state_nx == S_ISSUE) || (state_nx == S_DRAIN) || (state_nx == S_ERR);
    done_nx     = (state_nx == S_DONE);
    err_nx      = (state_nx == S_ERR);
    mem_rd_nx   = (state_nx == S_ISSUE);
    mem_addr_nx = mem_rd_nx ? base_nx + ADDR_W'(cnt_nx) : '0;
    rdata_nx    = (state_nx == S_DONE) ? extend(f3, lanes_nx) : rdata;
  end

endmodule
